// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: table sizes, key-schedule FSM states and key byte selection.
package rc4_pkg;

   localparam int unsigned KEY_BYTES = 3;
   localparam int unsigned S_SIZE    = 256;

   typedef enum logic [2:0] {
      IDLE,
      RD_I,
      WT_I,
      RD_J,
      WT_J,
      WR_I,
      WR_J,
      DONE
   } ksa_state_t;

   // Byte 0 is the most significant byte of the 24-bit key.
   function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
      logic [7:0] kb;
      case (idx)
         2'd0:    kb = key[23:16];
         2'd1:    kb = key[15:8];
         default: kb = key[7:0];
      endcase
      return kb;
   endfunction

endpackage

// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling engine: permutes the 256-byte S RAM in place through a single
// synchronous-read port, six cycles per iteration, under a start/complete handshake.
module ksa_shuffle #(
   parameter int unsigned KEY_BYTES = rc4_pkg::KEY_BYTES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        complete,
   input  logic [23:0] secret_key,
   input  logic [7:0]  q,
   output logic [7:0]  address,
   output logic [7:0]  data,
   output logic        wren
);
   import rc4_pkg::*;

   ksa_state_t state_q, state_d;
   logic [7:0] i_q, i_d;
   logic [7:0] j_q, j_d;
   logic [1:0] kidx_q, kidx_d;
   logic [7:0] si_q, si_d;
   logic [7:0] sj_q, sj_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         kidx_q  <= '0;
         si_q    <= '0;
         sj_q    <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         kidx_q  <= kidx_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      j_d      = j_q;
      kidx_d   = kidx_q;
      si_d     = si_q;
      sj_d     = sj_q;
      address  = '0;
      data     = '0;
      wren     = 1'b0;
      complete = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               i_d     = '0;
               j_d     = '0;
               kidx_d  = '0;
               state_d = RD_I;
            end
         end
         RD_I: begin
            address = i_q;
            state_d = WT_I;
         end
         WT_I: begin
            address = i_q;
            si_d    = q;
            j_d     = j_q + q + key_byte(secret_key, kidx_q);
            state_d = RD_J;
         end
         RD_J: begin
            address = j_q;
            state_d = WT_J;
         end
         WT_J: begin
            address = j_q;
            sj_d    = q;
            state_d = WR_I;
         end
         WR_I: begin
            address = i_q;
            data    = sj_q;
            wren    = 1'b1;
            state_d = WR_J;
         end
         WR_J: begin
            address = j_q;
            data    = si_q;
            wren    = 1'b1;
            // i stays at the last index on exit; IDLE clears it for the next run.
            if (i_q == 8'(S_SIZE - 1)) begin
               state_d = DONE;
            end else begin
               i_d     = i_q + 8'd1;
               kidx_d  = (kidx_q == 2'(KEY_BYTES - 1)) ? 2'd0 : kidx_q + 2'd1;
               state_d = RD_I;
            end
         end
         DONE: begin
            complete = 1'b1;
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
